fetch_buffered: RTL and testbench
=================================

// Module: fetch_buffered
// PURPOSE
// - Parametrised fetch stage with a prefetch queue, sitting between the PC/redirect logic and decode.
// - Keeps streaming requests into instr_mem at one per cycle.
// - Queues the returned {pc, instruction} pairs.
// - Presents the queue head to decode through a valid/ready handshake, so decode stalls do not stall memory issue.
// - An execute-stage redirect (pc_r/pc_exec) flushes the queue and any in-flight request.
// PARAMETERS
// - XLEN     32  width of PC and instruction words
// - DEPTH    4   prefetch queue entries; power of two, >= 2
// - PC_STEP  4   sequential PC increment in bytes
// PORTS
// - clk       in   1        single clock; all state updates on posedge clk
// - reset     in   1        synchronous, active-high reset
// - pc_init   in   XLEN     PC loaded at reset
// - pc_exec   in   XLEN     redirect target from execute
// - pc_r      in   1        redirect strobe, one cycle
// - de_ready  in   1        decode accepts the head entry this cycle
// - pc_out    out  XLEN     address presented to instr_mem this cycle
// - fe_valid  out  1        fe_to_de holds a valid entry
// - fe_to_de  out  fe_to_de_s  head entry {instruction_value, pc_value, pc_r}
// BEHAVIOUR
// - Reset (sync, at posedge with reset=1):
//   - pc<=pc_init; queue empty (rd/wr ptr 0, count 0); inflight<=0; redir_tag<=0.
//   - Outputs: fe_valid=0; fe_to_de='0 with pc_value=pc_init.
//   - Reset overrides redirect and the handshake.
// - Memory: instr_mem read is synchronous, 1-cycle latency. A request issued at edge N returns data sampled at edge N+1.
// - Issue rule, per cycle:
//   - issue = !reset && !pc_r && (count + inflight - deq) < DEPTH, where deq = fe_valid && de_ready.
//   - On issue: req_pc<=pc, req_tag<=redir_tag, pc<=pc+PC_STEP (XLEN-bit wrap at 2^XLEN), inflight<=1, redir_tag<=0.
//   - No issue: pc holds, inflight<=0.
// - Enqueue: if inflight && !pc_r, write {instr, req_pc, req_tag} at wr_ptr. Queue space is guaranteed by the issue rule; overflow is a design bug (assertion).
// - Dequeue: deq advances rd_ptr. Simultaneous enq+deq leaves count unchanged.
// - fe_valid = (count != 0). fe_to_de = entry at rd_ptr, held stable while fe_valid && !de_ready.
// - Redirect (pc_r=1), highest priority after reset:
//   - Outputs: pc<=pc_exec with bits [1:0] forced to 0; count/ptrs<=0; inflight<=0; redir_tag<=1.
//   - The in-flight response is discarded. No deq that cycle, even if de_ready=1.
//   - First entry fetched after a redirect carries pc_r=1; all others carry 0.
// - Latency:
//   - Redirect at edge R -> issue of pc_exec at edge R+1 -> fe_valid=1 after edge R+2.
//   - Reset release behaves the same.
//   - Steady state: 1 entry/cycle while de_ready=1.
// - Back-to-back redirects: each one restarts; only the last target is fetched.
// - Full: with de_ready=0, at most DEPTH entries are held. Issue stops when count+inflight==DEPTH.
//   - Issue resumes in the same cycle de_ready rises: deq credit counts immediately.
// - Pointers are log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.
// STRUCTURE
// - Package riscv_structures:
//   - Existing fe_to_de_s is reused as the queue entry type.
//   - Add localparam XLEN and FETCH_DEPTH defaults.
// - Sub-module fetch_fifo #(DEPTH, type T):
//   - Registered storage, push/pop/flush, count, head output.
//   - Combinational head read.
// - Top: PC register, request tracking (inflight/req_pc/req_tag), instr_mem instance, issue credit logic.
// - Assertions:
//   - no push when full;
//   - no pop when empty;
//   - fe_to_de stable while fe_valid && !de_ready.
// TESTING
// - Reset pc_init=0x100, de_ready=1 -> fe_valid rises 2 edges after release.
//   - Entries pc 0x100,0x104,0x108 on consecutive cycles, pc_r=0.
// - de_ready=0 for 10 cycles after stream starts -> exactly DEPTH=4 entries queued, pc_out frozen at head_pc+16.
//   - Release -> 0x100..0x10C then 0x110 with no gap or duplicate.
// - pc_r=1, pc_exec=0x200 while queue holds 3 entries and a request is in flight -> all discarded.
//   - Next valid entry pc 0x200 with pc_r=1; following entry 0x204 with pc_r=0.
// - Redirect in the same cycle as de_ready=1 && fe_valid=1 -> no dequeue counted.
//   - Two redirects on consecutive cycles (0x300, 0x400) -> only 0x400 stream appears.
// - pc_init=0xFFFFFFF8, de_ready=1 -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
//   - pc_exec=0x203 -> fetch from 0x200.
// - Assert reset mid-stream with queue full -> next cycle fe_valid=0, pc_out=pc_init.
//   - Stream restarts cleanly with first entry pc_r=0.

Source files
------------

// File: rtl/fetch_buffered_pkg.sv
// Shared types for the fetch stage: the fetch-to-decode entry and default sizes.
package riscv_structures;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_DEPTH = 4;

  // One decoded-side queue entry; pc_r marks the first fetch after a redirect.
  typedef struct packed {
    logic [XLEN-1:0] instruction_value;
    logic [XLEN-1:0] pc_value;
    logic            pc_r;
  } fe_to_de_s;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN/2-1:0], addr[XLEN-1:XLEN/2]} ^ XLEN'(32'hA5C3_3C5A);
  endfunction

endpackage

// File: rtl/fetch_buffered_if.sv
// Fetch-to-decode valid/ready handshake.
interface fetch_buffered_if;
  import riscv_structures::*;

  logic      fe_valid;
  logic      de_ready;
  fe_to_de_s fe_to_de;

  modport master (output fe_valid, output fe_to_de, input de_ready);
  modport slave  (input fe_valid, input fe_to_de, output de_ready);

endinterface

// File: rtl/fetch_buffered_fifo.sv
// Prefetch queue: registered storage, flush, occupancy count, combinational head.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wdata_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state: flush wins; otherwise push and pop act independently.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful under count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Issue credit logic must keep these from ever firing.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && full && !pop_i && !flush_i));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pop_i && empty && !flush_i));

endmodule

// File: rtl/fetch_buffered.sv
// Buffered fetch stage: PC sequencing, one-cycle instruction memory, prefetch
// queue, and redirect flush. Memory keeps issuing while decode stalls as long
// as queued plus in-flight entries fit.
module fetch_buffered
  import riscv_structures::*;
#(
  parameter int unsigned DEPTH   = FETCH_DEPTH,
  parameter int unsigned PC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_init,
  input  logic [XLEN-1:0]  pc_exec,
  input  logic             pc_r,
  output logic [XLEN-1:0]  pc_out,
  fetch_buffered_if.master de_if
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned NeedW = CntW + 1;
  localparam logic [NeedW-1:0] DepthN = NeedW'(DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             inflight_q, inflight_d;
  logic             req_tag_q, req_tag_d;
  logic             redir_tag_q, redir_tag_d;
  logic [CntW-1:0]  count;
  logic [NeedW-1:0] need;
  logic             deq, issue, push, pop;
  fe_to_de_s        head, wdata, idle_entry;

  // A dequeue this cycle frees a slot for a request issued this same cycle.
  assign deq   = de_if.fe_valid & de_if.de_ready;
  assign need  = NeedW'(count) + NeedW'(inflight_q) - NeedW'(deq);
  assign issue = !reset && !pc_r && (need < DepthN);

  // A redirect discards the returning response and suppresses the handshake.
  assign push  = inflight_q & ~pc_r;
  assign pop   = deq & ~pc_r;
  assign wdata = '{instruction_value: instr_q, pc_value: req_pc_q, pc_r: req_tag_q};

  // PC and request-tracking next state; redirect outranks issue.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_tag_d   = req_tag_q;
    redir_tag_d = redir_tag_q;
    inflight_d  = 1'b0;
    if (pc_r) begin
      pc_d        = pc_exec & ~XLEN'(3);
      redir_tag_d = 1'b1;
    end else if (issue) begin
      req_pc_d    = pc_q;
      req_tag_d   = redir_tag_q;
      pc_d        = pc_q + XLEN'(PC_STEP);
      inflight_d  = 1'b1;
      redir_tag_d = 1'b0;
    end
  end

  // Synchronous instruction memory read of the address presented this cycle.
  assign instr_d = mem_word(pc_q);

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= pc_init;
      req_pc_q    <= '0;
      req_tag_q   <= 1'b0;
      redir_tag_q <= 1'b0;
      inflight_q  <= 1'b0;
      instr_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_tag_q   <= req_tag_d;
      redir_tag_q <= redir_tag_d;
      inflight_q  <= inflight_d;
      instr_q     <= instr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fe_to_de_s)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (pc_r),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  // With an empty queue decode sees zeros plus the current fetch PC.
  assign idle_entry     = '{instruction_value: '0, pc_value: pc_q, pc_r: 1'b0};
  assign pc_out         = pc_q;
  assign de_if.fe_valid = (count != '0);
  assign de_if.fe_to_de = de_if.fe_valid ? head : idle_entry;

  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    (de_if.fe_valid && !de_if.de_ready && !pc_r) |=> $stable(de_if.fe_to_de));

endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: scoreboard of expected fetch stream per reset or
// redirect, a table of stream scenarios, and hand sequences for latency,
// full-queue, redirect and mid-stream reset cases.
module tb_fetch_buffered;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        tag;
  } exp_t;

  typedef struct {
    logic        is_reset;
    logic [31:0] addr;
    logic [15:0] rdy_mask;
    int          n_accept;
    logic [31:0] exp_first_pc;
    logic        exp_first_tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_init;
  logic [31:0] pc_exec;
  logic        pc_r;
  logic [31:0] pc_out;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  fetch_buffered_if de_if ();

  fetch_buffered #(
    .DEPTH   (4),
    .PC_STEP (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pc_init (pc_init),
    .pc_exec (pc_exec),
    .pc_r    (pc_r),
    .pc_out  (pc_out),
    .de_if   (de_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no result, expected a result", name);
  endtask

  task automatic fill(input logic [31:0] start, input logic first_tag);
    logic [31:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      sb.push_back('{pc: p, instr: model_instr(p), tag: (i == 0) ? first_tag : 1'b0});
      p = p + 32'd4;
    end
  endtask

  // Drive one cycle; a handshake that will complete at the coming edge is
  // checked against the scoreboard, then outputs are sampled 1 ns after it.
  task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt,
                       input logic rdy, output logic accepted);
    exp_t e;
    reset          = rst;
    pc_r           = redir;
    pc_exec        = tgt;
    de_if.de_ready = rdy;
    accepted       = 1'b0;
    if (!rst && !redir && de_if.fe_valid && rdy) begin
      accepted = 1'b1;
      if (sb.size() == 0) begin
        fail_now("scoreboard empty");
      end else begin
        e = sb.pop_front();
        check("head pc", de_if.fe_to_de.pc_value, e.pc);
        check("head instr", de_if.fe_to_de.instruction_value, e.instr);
        check("head pc_r", 32'(de_if.fe_to_de.pc_r), 32'(e.tag));
      end
    end
    if (rst) fill(pc_init, 1'b0);
    else if (redir) fill({tgt[31:2], 2'b00}, 1'b1);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    logic acc;
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{1'b1, 32'h0000_0100, 16'hFFFF, 6, 32'h0000_0100, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0203, 16'hAAAA, 6, 32'h0000_0200, 1'b1};
    vecs[2] = '{1'b1, 32'hFFFF_FFF8, 16'hFFFF, 4, 32'hFFFF_FFF8, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_1000, 16'h0F0F, 8, 32'h0000_1000, 1'b1};
    vecs[4] = '{1'b0, 32'h7FFF_FFFE, 16'h3333, 5, 32'h7FFF_FFFC, 1'b1};

    pc_init        = 32'h100;
    pc_exec        = '0;
    pc_r           = 1'b0;
    reset          = 1'b1;
    de_if.de_ready = 1'b1;

    // Reset state and release latency, then a short stream.
    cycle(1'b1, 1'b0, '0, 1'b1, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, acc);
    check("reset fe_valid", 32'(de_if.fe_valid), 32'd0);
    check("reset pc_value", de_if.fe_to_de.pc_value, 32'h100);
    check("reset instr", de_if.fe_to_de.instruction_value, 32'd0);
    check("reset pc_r", 32'(de_if.fe_to_de.pc_r), 32'd0);
    check("reset pc_out", pc_out, 32'h100);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("valid one edge after release", 32'(de_if.fe_valid), 32'd0);
    check("pc_out after first issue", pc_out, 32'h104);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("valid two edges after release", 32'(de_if.fe_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("stream valid", 32'(de_if.fe_valid), 32'd1);
      check("stream pc", de_if.fe_to_de.pc_value, 32'h100 + 32'(4 * i));
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
    end

    // Decode stalled from reset: queue fills to four, then drains with no gap.
    cycle(1'b1, 1'b0, '0, 1'b0, acc);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("full valid", 32'(de_if.fe_valid), 32'd1);
    check("full head pc", de_if.fe_to_de.pc_value, 32'h100);
    check("full pc_out frozen", pc_out, 32'h110);
    for (int i = 0; i < 6; i++) begin
      check("drain valid", 32'(de_if.fe_valid), 32'd1);
      check("drain pc", de_if.fe_to_de.pc_value, 32'h100 + 32'(4 * i));
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
    end

    // Redirect with three queued and one in flight, de_ready high that cycle.
    cycle(1'b1, 1'b0, '0, 1'b0, acc);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("pre-redirect valid", 32'(de_if.fe_valid), 32'd1);
    check("pre-redirect pc_out", pc_out, 32'h110);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, acc);
    check("redirect flushes valid", 32'(de_if.fe_valid), 32'd0);
    check("redirect pc_out", pc_out, 32'h200);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("redirect +1 valid", 32'(de_if.fe_valid), 32'd0);
    check("redirect +1 pc_out", pc_out, 32'h204);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("redirect +2 valid", 32'(de_if.fe_valid), 32'd1);
    check("redirect first pc", de_if.fe_to_de.pc_value, 32'h200);
    check("redirect first tag", 32'(de_if.fe_to_de.pc_r), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("redirect second pc", de_if.fe_to_de.pc_value, 32'h204);
    check("redirect second tag", 32'(de_if.fe_to_de.pc_r), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Back-to-back redirects: only the last target streams.
    cycle(1'b0, 1'b1, 32'h300, 1'b1, acc);
    cycle(1'b0, 1'b1, 32'h400, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("double redirect valid", 32'(de_if.fe_valid), 32'd1);
    check("double redirect pc", de_if.fe_to_de.pc_value, 32'h400);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Reset while the queue is full restarts cleanly from the new pc_init.
    cycle(1'b0, 1'b1, 32'h600, 1'b0, acc);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b0, acc);
    check("pre-reset pc_out full", pc_out, 32'h610);
    pc_init = 32'h500;
    cycle(1'b1, 1'b0, '0, 1'b0, acc);
    check("mid reset valid", 32'(de_if.fe_valid), 32'd0);
    check("mid reset pc_out", pc_out, 32'h500);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check("restart valid", 32'(de_if.fe_valid), 32'd1);
    check("restart pc", de_if.fe_to_de.pc_value, 32'h500);
    check("restart tag", 32'(de_if.fe_to_de.pc_r), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Table of stream scenarios with varying decode back-pressure.
    for (int r = 0; r < 5; r++) begin
      int   got;
      int   budget;
      int   k;
      logic rdy;
      got    = 0;
      budget = 200;
      k      = 0;
      if (vecs[r].is_reset) begin
        pc_init = vecs[r].addr;
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
      end else begin
        cycle(1'b0, 1'b1, vecs[r].addr, 1'b1, acc);
      end
      while (got < vecs[r].n_accept && budget > 0) begin
        rdy = vecs[r].rdy_mask[k % 16];
        if (got == 0 && de_if.fe_valid && rdy) begin
          check("row first pc", de_if.fe_to_de.pc_value, vecs[r].exp_first_pc);
          check("row first tag", 32'(de_if.fe_to_de.pc_r), 32'(vecs[r].exp_first_tag));
        end
        cycle(1'b0, 1'b0, '0, rdy, acc);
        if (acc) got++;
        k++;
        budget--;
      end
      if (got < vecs[r].n_accept) fail_now("row accept budget");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
